// File: rtl/sysarr_psum_drain.sv
// Systolic-array partial-sum drain: collects per-column results into a row and queues rows in a FWFT FIFO.
// Optional build macro SYSARR_DRAIN_RELU_EN applies FP16 ReLU at capture; NaNs pass through unchanged.
module sysarr_psum_drain #(
  parameter int N     = 4,
  parameter int DW    = 16,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            nRST,
  input  logic [N-1:0]    col_done,
  input  logic [N*DW-1:0] col_result,
  input  logic            flush,
  output logic            drain_stall,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*DW-1:0] out_row,
  output logic            overrun,
  output logic [15:0]     rows_out,
  output logic            dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - 1);

  typedef enum logic {COLLECT = 1'b0, PUSH = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    mask_q, mask_d;
  logic [N*DW-1:0] buf_q, buf_d;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;
  logic            stall_q, stall_d;
  logic            overrun_q, overrun_d;
  logic [15:0]     rows_q, rows_d;
  logic            push, pop;
  logic [N*DW-1:0] mem [DEPTH];

  function automatic logic [DW-1:0] capture_word(input logic [DW-1:0] w);
`ifdef SYSARR_DRAIN_RELU_EN
    logic is_nan;
    is_nan = (w[DW-2 -: 5] == 5'h1f) && (w[DW-7:0] != '0);
    if (w[DW-1] && !is_nan) capture_word = '0;
    else                    capture_word = w;
`else
    capture_word = w;
`endif
  endfunction

  // Handshake: a row transfers on every edge where out_valid && out_ready;
  // out_row is held stable while out_valid && !out_ready.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    buf_d     = buf_q;
    overrun_d = overrun_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    count_d   = count_q;
    rows_d    = rows_q;
    push      = (state_q == PUSH) && (count_q != FULL_LVL) && !flush;
    pop       = (count_q != '0) && out_ready && !flush;

    if (!flush) begin
      for (int c = 0; c < N; c++) begin
        if (col_done[c]) begin
          if (!mask_q[c]) begin
            buf_d[c*DW +: DW] = capture_word(col_result[c*DW +: DW]);
            mask_d[c]         = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
    end

    // Entering PUSH on the edge that completes the mask gives the 2-cycle drain latency.
    case (state_q)
      COLLECT: if (&mask_d) state_d = PUSH;
      PUSH: begin
        if (push) begin
          mask_d  = '0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    if (push) wr_d = wr_q + AW'(1);
    if (pop) begin
      rd_d   = rd_q + AW'(1);
      rows_d = rows_q + 16'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      mask_d  = '0;
      state_d = COLLECT;
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end

    stall_d = (state_d == PUSH) || (count_d >= STALL_LVL);
  end

  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      state_q   <= COLLECT;
      mask_q    <= '0;
      buf_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      stall_q   <= 1'b0;
      overrun_q <= 1'b0;
      rows_q    <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      buf_q     <= buf_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      stall_q   <= stall_d;
      overrun_q <= overrun_d;
      rows_q    <= rows_d;
    end
  end

  // Storage needs no reset: out_row is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= buf_q;
  end

  assign out_valid   = (count_q != '0);
  assign out_row     = out_valid ? mem[rd_q] : '0;
  assign drain_stall = stall_q;
  assign overrun     = overrun_q;
  assign rows_out    = rows_q;
  assign dbg_state   = (state_q == PUSH);

endmodule

// File: tb/tb_sysarr_psum_drain.sv
// Self-checking bench for sysarr_psum_drain (N=4, DW=16, DEPTH=2); expected rows are queued as columns are driven.
module tb_sysarr_psum_drain;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int RW = N * DW;

  logic          clk = 1'b0;
  logic          nRST;
  logic [N-1:0]  col_done;
  logic [RW-1:0] col_result;
  logic          flush;
  logic          drain_stall;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_row;
  logic          overrun;
  logic [15:0]   rows_out;
  logic          dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [RW-1:0] exp_q[$];
  logic [15:0]   exp_rows = 16'd0;
  logic          prev_hold = 1'b0;
  logic [RW-1:0] prev_row = '0;

  sysarr_psum_drain #(.N(N), .DW(DW), .DEPTH(2)) dut (
    .clk(clk), .nRST(nRST), .col_done(col_done), .col_result(col_result),
    .flush(flush), .drain_stall(drain_stall), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .overrun(overrun),
    .rows_out(rows_out), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_word(input logic [15:0] w);
`ifdef SYSARR_DRAIN_RELU_EN
    if (w[15] && !((w[14:10] == 5'h1f) && (w[9:0] != 10'd0))) return 16'h0000;
`endif
    return w;
  endfunction

  function automatic logic [RW-1:0] model_row(input logic [15:0] v [N]);
    logic [RW-1:0] r;
    for (int c = 0; c < N; c++) r[c*DW +: DW] = model_word(v[c]);
    return r;
  endfunction

  // Consumer-side scoreboard, sampled away from the active edge.
  always @(negedge clk) begin
    check("rows_out", {48'd0, rows_out}, {48'd0, exp_rows});
    if (prev_hold && out_valid) check("hold_stable", out_row, prev_row);
    if (out_valid && exp_q.size() == 0) check("spurious_valid", {63'd0, out_valid}, 64'd0);
    if (out_valid && out_ready) begin
      if (exp_q.size() != 0) check("out_row", out_row, exp_q.pop_front());
      exp_rows = exp_rows + 16'd1;
    end
    prev_hold = out_valid && !out_ready;
    prev_row  = out_row;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cols(input logic [N-1:0] m, input logic [15:0] v [N]);
    col_result = {$urandom, $urandom};
    for (int c = 0; c < N; c++) if (m[c]) col_result[c*DW +: DW] = v[c];
    col_done = m;
    step();
    col_done = '0;
  endtask

  // Drives one row (all at once, or random column subsets) and queues its expected value.
  task automatic send_row(input logic [15:0] v [N], input bit at_once, input bit rnd_ready);
    logic [N-1:0] rem, sub;
    rem = '1;
    while (rem != '0) begin
      sub = at_once ? rem : (rem & N'($urandom));
      if (sub == '0) sub = rem & (~rem + N'(1));
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      exp_q.push_back(model_row(v)) ;
      if (sub != rem) void'(exp_q.pop_back());
      drive_cols(sub, v);
      rem = rem & ~sub;
    end
  endtask

  task automatic rand_vals(output logic [15:0] v [N]);
    for (int c = 0; c < N; c++) v[c] = 16'($urandom);
  endtask

  task automatic wait_no_stall(input int budget);
    int n = 0;
    while (drain_stall && n < budget) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    if (drain_stall) check("stall_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() != 0 || out_valid) check("drain_timeout", 64'd1, 64'd0);
    out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] v [N];
    logic [15:0] saved_rows;
    nRST = 1'b1; col_done = '0; col_result = '0; flush = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_row", out_row, 64'd0);
    check("rst_drain_stall", {63'd0, drain_stall}, 64'd0);
    check("rst_overrun", {63'd0, overrun}, 64'd0);
    check("rst_state", {63'd0, dbg_state}, 64'd0);
    step(); step();
    nRST = 1'b0;
    step();

    // Columns 0..3 in consecutive cycles; latency and content.
    v = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
    for (int c = 0; c < N; c++) drive_cols(N'(1 << c), v);
    exp_q.push_back(64'h4400_4200_4000_3C00);
    check("lat1_valid", {63'd0, out_valid}, 64'd0);
    check("lat1_stall", {63'd0, drain_stall}, 64'd1);
    check("lat1_state", {63'd0, dbg_state}, 64'd1);
    step();
    check("lat2_valid", {63'd0, out_valid}, 64'd1);
    check("lat2_row", out_row, 64'h4400_4200_4000_3C00);
    check("lat2_stall", {63'd0, drain_stall}, 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("basic_rows_out", {48'd0, rows_out}, 64'd1);
    check("basic_empty", {63'd0, out_valid}, 64'd0);

    // Sign, -0, -inf and NaN words: bit-exact by default, ReLU when enabled.
    v = '{16'hC000, 16'h7E01, 16'h8000, 16'hFE01};
    send_row(v, 1'b1, 1'b0);
    step(); step();
    check("relu_row", out_row, model_row(v));
`ifdef SYSARR_DRAIN_RELU_EN
    check("relu_c000", {48'd0, out_row[15:0]}, 64'h0000);
`else
    check("exact_c000", {48'd0, out_row[15:0]}, 64'hC000);
`endif
    check("nan_7e01", {48'd0, out_row[31:16]}, 64'h7E01);
    wait_drain(20);

    // Fill the FIFO with ready low; third row held in PUSH until a pop.
    for (int r = 0; r < 3; r++) begin
      rand_vals(v);
      send_row(v, 1'b1, 1'b0);
      if (r < 2) step();
    end
    step();
    check("full_state", {63'd0, dbg_state}, 64'd1);
    check("full_stall", {63'd0, drain_stall}, 64'd1);
    check("full_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bubble_state", {63'd0, dbg_state}, 64'd1);
    step();
    check("late_push_state", {63'd0, dbg_state}, 64'd0);
    check("late_push_stall", {63'd0, drain_stall}, 64'd1);
    wait_drain(40);

    // Flush with two queued rows and a partial mask of 0101.
    for (int r = 0; r < 2; r++) begin
      rand_vals(v);
      send_row(v, 1'b1, 1'b0);
      step();
    end
    rand_vals(v);
    drive_cols(4'b0101, v);
    saved_rows = rows_out;
    flush = 1'b1;
    col_done = '1;
    col_result = {$urandom, $urandom};
    step();
    flush = 1'b0;
    col_done = '0;
    exp_q.delete();
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    check("flush_state", {63'd0, dbg_state}, 64'd0);
    check("flush_stall", {63'd0, drain_stall}, 64'd0);
    check("flush_rows", {48'd0, rows_out}, {48'd0, saved_rows});
    rand_vals(v);
    for (int c = 0; c < N; c++) drive_cols(N'(1 << c), v);
    exp_q.push_back(model_row(v));
    wait_drain(20);
    check("flush_no_overrun", {63'd0, overrun}, 64'd0);

    // Double completion on column 2 keeps the first value and sets sticky overrun.
    rand_vals(v);
    drive_cols(4'b0100, v);
    exp_q.push_back(model_row(v));
    v[2] = ~v[2];
    drive_cols(4'b0100, v);
    check("overrun_set", {63'd0, overrun}, 64'd1);
    drive_cols(4'b1011, v);
    wait_drain(20);
    check("overrun_sticky", {63'd0, overrun}, 64'd1);

    // Random rows, random column grouping and random consumer back-pressure.
    for (int r = 0; r < 12; r++) begin
      wait_no_stall(200);
      rand_vals(v);
      send_row(v, 1'b0, 1'b1);
    end
    wait_drain(100);

    // Reset while a row is held in PUSH.
    for (int r = 0; r < 3; r++) begin
      rand_vals(v);
      send_row(v, 1'b1, 1'b0);
      step();
    end
    check("pre_rst_state", {63'd0, dbg_state}, 64'd1);
    #2;
    nRST = 1'b1;
    exp_rows = 16'd0;
    exp_q.delete();
    #1;
    check("arst_valid", {63'd0, out_valid}, 64'd0);
    check("arst_row", out_row, 64'd0);
    check("arst_stall", {63'd0, drain_stall}, 64'd0);
    check("arst_overrun", {63'd0, overrun}, 64'd0);
    check("arst_rows", {48'd0, rows_out}, 64'd0);
    check("arst_state", {63'd0, dbg_state}, 64'd0);
    step();
    nRST = 1'b0;
    rand_vals(v);
    send_row(v, 1'b0, 1'b0);
    wait_drain(20);
    check("post_rst_rows", {48'd0, rows_out}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sysarr_psum_drain.md
SYSARR_PSUM_DRAIN -- requirements
Module: sysarr_psum_drain

Interface
REQ-001 The block SHALL have parameter N, default 4: number of systolic-array columns drained.
REQ-002 The block SHALL have parameter DW, default 16: FP16 word width.
REQ-003 The block SHALL have parameter DEPTH, default 2: output FIFO entries, a power of two and at least 2.
REQ-004 The block SHALL have a clock port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have a reset port: nRST  in  1  asynchronous, active-high reset (port keeps the codebase name; asserted = 1).
REQ-006 The block SHALL have an input col_done: col_done  in  N  per-column MAC completion pulse, one cycle wide.
REQ-007 The block SHALL have an input col_result: col_result  in  N*DW  per-column out_accumulate, column c at bits [c*DW +: DW].
REQ-008 The block SHALL have an input flush: flush  in  1  discards the partial row and all FIFO contents.
REQ-009 The block SHALL have an output drain_stall: drain_stall  out  1  back-pressure to the array controller; when 1, no new row may be started.
REQ-010 The block SHALL have an output out_valid: out_valid  out  1  out_row holds a complete row.
REQ-011 The block SHALL have an input out_ready: out_ready  in  1  consumer accepts out_row.
REQ-012 The block SHALL have an output out_row: out_row  out  N*DW  oldest complete row.
REQ-013 The block SHALL have an output overrun: overrun  out  1  sticky error flag.
REQ-014 The block SHALL have an output rows_out: rows_out  out  16  count of rows handed off, wrapping.

Function
REQ-015 The block SHALL keep a capture buffer of N×DW bits and an N-bit capture mask.
REQ-016 When col_done[c]=1 and mask[c]=0, the block SHALL register col_result[c] into the buffer and set mask[c] in that cycle; any subset of columns may complete in the same cycle.
REQ-017 When col_done[c]=1 and mask[c]=1, the block SHALL set overrun and leave the buffer and mask unchanged.
REQ-018 The block SHALL implement a two-state FSM, COLLECT and PUSH, which resets into COLLECT.
REQ-019 In COLLECT, once the mask is all ones, the FSM SHALL move to PUSH on the next edge.
REQ-020 In PUSH, if the FIFO is not full, the block SHALL write the buffer into the FIFO, clear the mask and return to COLLECT in one cycle.
REQ-021 In PUSH, if the FIFO is full, the block SHALL stay in PUSH and hold the buffer.
REQ-022 drain_stall SHALL be a registered output equal to (state==PUSH) OR (FIFO count ≥ DEPTH-1).
REQ-023 The FIFO SHALL be first-word-fall-through: out_valid is 1 whenever count > 0, and out_row is the head entry.
REQ-024 A FIFO pop SHALL occur on out_valid & out_ready; on each pop, rows_out SHALL increment, wrapping from 0xFFFF to 0.
REQ-025 A simultaneous push and pop with the FIFO full SHALL NOT be allowed; the push waits one cycle, which gives a 1-cycle bubble and no combinational ready path.
REQ-026 A simultaneous push and pop with the FIFO not full SHALL leave count unchanged.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
REQ-028 out_row SHALL hold stable while out_valid=1 and out_ready=0.
REQ-029 flush SHALL, at the next edge, clear the mask, empty the FIFO and force COLLECT; col_done in a flush cycle SHALL be ignored; overrun and rows_out SHALL be kept.
REQ-030 Latency from the last col_done of a row to out_valid SHALL be 2 cycles when the FIFO has space.

Reset
REQ-031 While nRST=1, asynchronously: state=COLLECT, mask=0, FIFO empty, buffer=0.
REQ-032 While nRST=1, the outputs SHALL be out_valid=0, out_row=0, drain_stall=0, overrun=0, rows_out=0.
REQ-033 Reset asserted mid-row or mid-PUSH SHALL discard all data; the first edge after release behaves as a fresh COLLECT.

Configuration
REQ-034 With SYSARR_DRAIN_RELU_EN defined, each word SHALL be replaced by 16'h0000 at capture when its sign bit is 1, including -0 and negative infinity; NaN inputs (exp=31, frac≠0) SHALL pass unchanged.
REQ-035 Without SYSARR_DRAIN_RELU_EN defined, words SHALL be captured bit-exact.

Verification
REQ-036 N=4: col_done pulses on columns 0, 1, 2, 3 in consecutive cycles with results 3C00, 4000, 4200, 4400 -> out_valid 2 cycles after column 3, out_row={4400,4200,4000,3C00}, rows_out=1 after the pop.
REQ-037 All four col_done asserted in one cycle -> one row pushed; out_ready held 0 for 3 rows -> FIFO fills, drain_stall=1, the third row is held in PUSH and enters the FIFO the cycle after the first pop.
REQ-038 col_done[2] pulsed twice before the row completes -> overrun=1 and stays 1, and the first captured value is retained.
REQ-039 flush asserted with 2 FIFO entries and mask=0101 -> next cycle out_valid=0, mask=0, rows_out unchanged.
REQ-040 With RELU enabled, column value C000 -> captured as 0000; column value 7E01 -> captured as 7E01.
REQ-041 nRST pulsed while in PUSH -> all outputs return to their REQ-032 values asynchronously, and the next full row drains normally.
